// File: rtl/osc_mon_pkg.sv
// ---------------------------------------------------------------------------
// osc_mon_pkg
// Shared types and constants for the oscillator frequency/presence monitor.
//   mon_state_e       : monitor FSM state encoding
//   DEF_*             : default parameter values (1 MHz clock, 50 MHz fabric)
//   cnt_width()       : counter width needed to hold 0..n-1
// ---------------------------------------------------------------------------
package osc_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_MEASURE = 2'd2
    } mon_state_e;

    localparam int DEF_WINDOW_CYCLES = 1000;
    localparam int DEF_MIN_EDGES     = 19;
    localparam int DEF_MAX_EDGES     = 21;
    localparam int DEF_WARMUP_CYCLES = 256;
    localparam int DEF_GOOD_WINDOWS  = 4;
    localparam int DEF_CNT_W         = 16;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/osc_clk_monitor_if.sv
// ---------------------------------------------------------------------------
// osc_clk_monitor_if
// Signal bundle between the oscillator monitor and its system user.
//   MON_CLK    : monitored oscillator output (asynchronous to CLK)
//   MON_EN     : monitor enable, level
//   CLR_FAIL   : one-cycle pulse clearing MON_FAIL
//   MON_OK     : oscillator qualified good
//   MON_FAIL   : sticky out-of-band fault
//   MEAS_VALID : one-cycle pulse when MEAS_COUNT updates
//   MEAS_COUNT : edge count of the last completed window
// master = system side driving the controls, slave = the monitor itself.
// ---------------------------------------------------------------------------
interface osc_clk_monitor_if import osc_mon_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             MON_CLK;
    logic             MON_EN;
    logic             CLR_FAIL;
    logic             MON_OK;
    logic             MON_FAIL;
    logic             MEAS_VALID;
    logic [CNT_W-1:0] MEAS_COUNT;

    modport master (
        output MON_CLK, MON_EN, CLR_FAIL,
        input  MON_OK, MON_FAIL, MEAS_VALID, MEAS_COUNT
    );

    modport slave (
        input  MON_CLK, MON_EN, CLR_FAIL,
        output MON_OK, MON_FAIL, MEAS_VALID, MEAS_COUNT
    );

endinterface

// File: rtl/osc_edge_sync.sv
// ---------------------------------------------------------------------------
// osc_edge_sync
// Brings an asynchronous clock-like signal into the i_clk domain as data and
// emits a registered one-cycle strobe per rising edge. Latency from the
// input rising to o_edge high is 3 i_clk cycles (2 sync stages + strobe reg).
//   i_clk   : sampling clock
//   i_rst_n : synchronous active-low reset
//   i_async : asynchronous input
//   o_edge  : rising-edge strobe, one i_clk cycle wide
// ---------------------------------------------------------------------------
module osc_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync_d;
    logic r_edge;

    // Two-stage synchroniser, a delayed copy for edge detect, and the strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
            r_edge   <= 1'b0;
        end else begin
            r_sync1  <= i_async;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            r_edge   <= r_sync2 & ~r_sync_d;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/osc_clk_monitor.sv
// ---------------------------------------------------------------------------
// osc_clk_monitor
// Counts rising edges of a slow oscillator over fixed windows of CLK cycles
// and qualifies the result against an in-band edge count range.
//   CLK     : fabric clock
//   RESET_N : synchronous active-low reset
//   bus     : osc_clk_monitor_if.slave (MON_CLK/MON_EN/CLR_FAIL in,
//             MON_OK/MON_FAIL/MEAS_VALID/MEAS_COUNT out, all registered)
// ---------------------------------------------------------------------------
module osc_clk_monitor import osc_mon_pkg::*; #(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int MIN_EDGES     = DEF_MIN_EDGES,
    parameter int MAX_EDGES     = DEF_MAX_EDGES,
    parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
    parameter int GOOD_WINDOWS  = DEF_GOOD_WINDOWS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic               CLK,
    input  logic               RESET_N,
    osc_clk_monitor_if.slave   bus
);

    localparam int WIN_W  = cnt_width(WINDOW_CYCLES);
    localparam int WARM_W = cnt_width(WARMUP_CYCLES);
    localparam int GOOD_W = cnt_width(GOOD_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_LAST  = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_LO     = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0]  CNT_HI     = CNT_W'(MAX_EDGES);
    localparam logic [GOOD_W-1:0] GOOD_FULL  = GOOD_W'(GOOD_WINDOWS);

    mon_state_e         r_state;
    logic [WARM_W-1:0]  r_warm_cnt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic [GOOD_W-1:0]  r_good_cnt;
    logic               r_mon_ok;
    logic               r_mon_fail;
    logic               r_meas_valid;
    logic [CNT_W-1:0]   r_meas_count;

    logic               w_edge;
    logic               w_win_end;
    logic               w_in_band;
    logic [CNT_W-1:0]   w_final_cnt;
    logic [GOOD_W-1:0]  w_good_next;

    osc_edge_sync u_edge_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_async (bus.MON_CLK),
        .o_edge  (w_edge)
    );

    // Edge count including this cycle's strobe, so an edge on the terminal
    // cycle lands in the closing window; verdict and good-count successor.
    always_comb begin
        w_final_cnt = r_edge_cnt;
        w_good_next = r_good_cnt;
        if (w_edge && (r_edge_cnt != CNT_SAT)) begin
            w_final_cnt = r_edge_cnt + CNT_W'(1'b1);
        end else begin
            w_final_cnt = r_edge_cnt;
        end
        if (r_good_cnt != GOOD_FULL) begin
            w_good_next = r_good_cnt + GOOD_W'(1'b1);
        end else begin
            w_good_next = r_good_cnt;
        end
        w_win_end = (r_state == ST_MEASURE) && (r_win_cnt == WIN_LAST);
        w_in_band = (w_final_cnt >= CNT_LO) && (w_final_cnt <= CNT_HI);
    end

    // FSM, warmup/window/edge counters, measurement result and MON_OK.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state      <= ST_IDLE;
            r_warm_cnt   <= '0;
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_good_cnt   <= '0;
            r_mon_ok     <= 1'b0;
            r_meas_valid <= 1'b0;
            r_meas_count <= '0;
        end else if (!bus.MON_EN) begin
            // Disable discards any partial window; MEAS_COUNT holds.
            r_state      <= ST_IDLE;
            r_warm_cnt   <= '0;
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_good_cnt   <= '0;
            r_mon_ok     <= 1'b0;
            r_meas_valid <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_WARMUP;
                    r_warm_cnt <= '0;
                end
                ST_WARMUP: begin
                    // Edges seen during warmup are deliberately dropped.
                    if (r_warm_cnt == WARM_LAST) begin
                        r_state    <= ST_MEASURE;
                        r_win_cnt  <= '0;
                        r_edge_cnt <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + WARM_W'(1'b1);
                    end
                end
                ST_MEASURE: begin
                    if (w_win_end) begin
                        r_win_cnt    <= '0;
                        r_edge_cnt   <= '0;
                        r_meas_count <= w_final_cnt;
                        r_meas_valid <= 1'b1;
                        if (w_in_band) begin
                            r_good_cnt <= w_good_next;
                            r_mon_ok   <= (w_good_next == GOOD_FULL);
                        end else begin
                            r_good_cnt <= '0;
                            r_mon_ok   <= 1'b0;
                        end
                    end else begin
                        r_win_cnt  <= r_win_cnt + WIN_W'(1'b1);
                        r_edge_cnt <= w_final_cnt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky fault: an out-of-band verdict outranks a coincident clear.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_mon_fail <= 1'b0;
        end else if (bus.MON_EN && w_win_end && !w_in_band) begin
            r_mon_fail <= 1'b1;
        end else if (bus.CLR_FAIL) begin
            r_mon_fail <= 1'b0;
        end else begin
            r_mon_fail <= r_mon_fail;
        end
    end

    assign bus.MON_OK     = r_mon_ok;
    assign bus.MON_FAIL   = r_mon_fail;
    assign bus.MEAS_VALID = r_meas_valid;
    assign bus.MEAS_COUNT = r_meas_count;

endmodule

// File: tb/tb_osc_clk_monitor.sv
// ---------------------------------------------------------------------------
// tb_osc_clk_monitor
// Directed bench for osc_clk_monitor with a scoreboard of expected window
// results. MON_CLK is shaped per window so that its last rising edge falls
// on the terminal window cycle; 50-cycle spacing is 1 MHz at 50 MHz CLK.
// ---------------------------------------------------------------------------
module tb_osc_clk_monitor;

    localparam int WIN  = 1000;
    localparam int WARM = 256;
    localparam int CW   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    osc_clk_monitor_if #(.CNT_W(CW)) bus ();

    osc_clk_monitor #(
        .WINDOW_CYCLES (WIN),
        .MIN_EDGES     (19),
        .MAX_EDGES     (21),
        .WARMUP_CYCLES (WARM),
        .GOOD_WINDOWS  (4),
        .CNT_W         (CW)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          ok;
        logic          fail;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic ok, input logic fail);
        exp_t e;
        e.cnt  = CW'(c);
        e.ok   = ok;
        e.fail = fail;
        sb.push_back(e);
    endtask

    // Called in the cycle where MEAS_VALID is expected high.
    task automatic check_result(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_valid"}, bus.MEAS_VALID, 1);
        chk({tag, "_count"}, bus.MEAS_COUNT, e.cnt);
        chk({tag, "_ok"},    bus.MON_OK,     e.ok);
        chk({tag, "_fail"},  bus.MON_FAIL,   e.fail);
    endtask

    // n rising edges spaced sp cycles, last one at window cycle 996.
    function automatic logic win_pat(input int k, input int n, input int sp);
        int first;
        int d;
        if (n == 0) return 1'b0;
        first = 996 - sp * (n - 1);
        if (k < first) return 1'b0;
        d = k - first;
        return ((d / sp) < n) && ((d % sp) < (sp / 2));
    endfunction

    // Free-running clock, phase-continuous with win_pat(k, 20, 50).
    function automatic logic per_pat(input int k, input int sp);
        int m;
        m = ((k - 46) % sp + sp) % sp;
        return m < (sp / 2);
    endfunction

    // Starts one cycle after a window opens; len==WIN runs to the next result.
    task automatic drive_window(input string tag, input int n, input int sp,
                                input int clr_at, input int len);
        int stray;
        stray = 0;
        for (int k = 0; k < len; k++) begin
            bus.MON_CLK  = win_pat(k, n, sp);
            bus.CLR_FAIL = (k == clr_at);
            @(posedge clk);
            #1;
            if ((bus.MEAS_VALID === 1'b1) && !((len == WIN) && (k == len - 1))) stray++;
        end
        bus.CLR_FAIL = 1'b0;
        chk({tag, "_stray_valid"}, stray, 0);
        if (len == WIN) check_result(tag);
    endtask

    // Starts in the enable cycle; first result due WARM+WIN+2 cycles later.
    task automatic wait_first_valid(input string tag, input int bound);
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && (n < bound)) begin
            bus.MON_CLK = per_pat(n - (WARM + 1), 50);
            @(posedge clk);
            #1;
            n++;
            if (bus.MEAS_VALID === 1'b1) seen = 1'b1;
        end
        chk({tag, "_latency"}, n + 1, WARM + WIN + 2);
        check_result(tag);
    endtask

    task automatic check_reset_outputs(input string tag, input logic exp_fail, input int exp_cnt);
        chk({tag, "_ok"},    bus.MON_OK,     0);
        chk({tag, "_fail"},  bus.MON_FAIL,   exp_fail);
        chk({tag, "_valid"}, bus.MEAS_VALID, 0);
        chk({tag, "_count"}, bus.MEAS_COUNT, exp_cnt);
    endtask

    initial begin
        int stray;
        bus.MON_CLK  = 1'b0;
        bus.MON_EN   = 1'b0;
        bus.CLR_FAIL = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset", 1'b0, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_valid", bus.MEAS_VALID, 0);

        // 1 MHz: qualify after four good windows.
        bus.MON_EN = 1'b1;
        push_exp(20, 1'b0, 1'b0);
        wait_first_valid("w1", 3000);
        push_exp(20, 1'b0, 1'b0); drive_window("w2", 20, 50, -1, WIN);
        push_exp(20, 1'b0, 1'b0); drive_window("w3", 20, 50, -1, WIN);
        push_exp(20, 1'b1, 1'b0); drive_window("w4", 20, 50, -1, WIN);
        push_exp(20, 1'b1, 1'b0); drive_window("w5", 20, 50, -1, WIN);

        // Stuck low.
        push_exp(0, 1'b0, 1'b1);  drive_window("stuck", 0, 50, -1, WIN);

        // 2 MHz, then a clear coincident with the next out-of-band verdict.
        push_exp(40, 1'b0, 1'b1); drive_window("f2m_a", 40, 25, -1, WIN);
        push_exp(40, 1'b0, 1'b1); drive_window("f2m_clr", 40, 25, 999, WIN);

        // Back to 1 MHz, clear between verdicts, requalify.
        push_exp(20, 1'b0, 1'b0); drive_window("rq1", 20, 50, 500, WIN);
        push_exp(20, 1'b0, 1'b0); drive_window("rq2", 20, 50, -1, WIN);
        push_exp(20, 1'b0, 1'b0); drive_window("rq3", 20, 50, -1, WIN);
        push_exp(20, 1'b1, 1'b0); drive_window("rq4", 20, 50, -1, WIN);

        // Boundary counts, last edge always on the terminal cycle.
        push_exp(18, 1'b0, 1'b1); drive_window("b18", 18, 50, -1, WIN);
        push_exp(19, 1'b0, 1'b0); drive_window("b19", 19, 50, 500, WIN);
        push_exp(21, 1'b0, 1'b0); drive_window("b21", 21, 45, -1, WIN);
        push_exp(22, 1'b0, 1'b1); drive_window("b22", 22, 45, -1, WIN);

        // Reset pulse mid-window.
        drive_window("pre_rst", 20, 50, -1, 500);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst", 1'b0, 0);
        rst_n = 1'b1;
        push_exp(20, 1'b0, 1'b0);
        wait_first_valid("post_rst", 3000);

        // Set the fault, requalify, then drop MON_EN mid-window.
        push_exp(22, 1'b0, 1'b1); drive_window("e22", 22, 45, -1, WIN);
        push_exp(20, 1'b0, 1'b1); drive_window("e1", 20, 50, -1, WIN);
        push_exp(20, 1'b0, 1'b1); drive_window("e2", 20, 50, -1, WIN);
        push_exp(20, 1'b0, 1'b1); drive_window("e3", 20, 50, -1, WIN);
        push_exp(20, 1'b1, 1'b1); drive_window("e4", 20, 50, -1, WIN);
        drive_window("pre_dis", 20, 50, -1, 300);
        bus.MON_EN  = 1'b0;
        bus.MON_CLK = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("dis", 1'b1, 20);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.MEAS_VALID === 1'b1) stray++;
        end
        chk("dis_stray_valid", stray, 0);
        bus.MON_EN = 1'b1;
        push_exp(20, 1'b0, 1'b1);
        wait_first_valid("reen", 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no summary, expected summary before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
